sreg_sched: RTL and testbench

Round-robin scheduler that shares the single 42-bit serial shift-register output chain among `N_REQ` requesters. It captures one requester's word, hands it to the shift-register controller over a valid/ready handshake, waits for that controller's end-of-shift pulse, then drives a latch strobe so the downstream register chain updates in parallel. A timeout returns the scheduler to idle if the serializer never completes.

---
 rtl/sreg_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/sreg_sched.sv | 115 +++++++++++
 tb/tb_sreg_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sreg_pkg.sv
// Shared definitions for the serial shift-register output path.
package sreg_pkg;

   localparam int unsigned SREG_WORD_W = 42;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitDone,
      StLatch
   } sreg_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_grant,
   output logic [N_REQ-1:0]         gnt_oh,
   output logic [$clog2(N_REQ)-1:0] gnt_idx,
   output logic                     any_req
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] cand;
   logic             found;

   assign any_req = |req;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      cand    = '0;
      found   = 1'b0;
      // k = N_REQ lands back on last_grant itself, so it has lowest priority.
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((32'(last_grant) + k) % N_REQ);
         if (!found && req[cand]) begin
            found        = 1'b1;
            gnt_oh[cand] = 1'b1;
            gnt_idx      = cand;
         end
      end
   end

endmodule

// File: rtl/sreg_sched.sv
// Round-robin scheduler feeding one shared shift-register chain: capture, hand off,
// wait for end-of-shift, then strobe the parallel latch. Aborts to idle on timeout.
module sreg_sched
   import sreg_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned WORD_W    = SREG_WORD_W,
   parameter int unsigned LATCH_CYC = 4,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*WORD_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ack,
   output logic                      ser_valid,
   input  logic                      ser_ready,
   output logic [WORD_W-1:0]         ser_data,
   input  logic                      ser_done,
   output logic                      latch,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy,
   output logic                      err_timeout
);

   localparam int unsigned IDX_W  = $clog2(N_REQ);
   localparam int unsigned TCNT_W = $clog2(TIMEOUT);
   localparam int unsigned LCNT_W = $clog2(LATCH_CYC + 1);

   sreg_sched_state_t state;
   logic [IDX_W-1:0]  last_grant;
   logic [TCNT_W-1:0] tcnt;
   logic [LCNT_W-1:0] lcnt;

   logic [N_REQ-1:0]  gnt_oh;
   logic [IDX_W-1:0]  gnt_idx;
   logic              any_req;
   logic [WORD_W-1:0] win_word;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt_oh     (gnt_oh),
      .gnt_idx    (gnt_idx),
      .any_req    (any_req)
   );

   assign win_word = req_data[gnt_idx*WORD_W +: WORD_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         last_grant  <= IDX_W'(N_REQ - 1);
         tcnt        <= '0;
         lcnt        <= '0;
         req_ack     <= '0;
         ser_valid   <= 1'b0;
         ser_data    <= '0;
         latch       <= 1'b0;
         grant_id    <= '0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         req_ack     <= '0;
         err_timeout <= 1'b0;
         unique case (state)
            StIdle: begin
               if (any_req) begin
                  ser_data   <= win_word;
                  grant_id   <= gnt_idx;
                  last_grant <= gnt_idx;
                  req_ack    <= gnt_oh;
                  ser_valid  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= StIssue;
               end
            end
            StIssue: begin
               if (ser_ready) begin
                  ser_valid <= 1'b0;
                  tcnt      <= '0;
                  state     <= StWaitDone;
               end
            end
            StWaitDone: begin
               // ser_done is checked first so a completion on the last cycle still latches.
               if (ser_done) begin
                  latch <= 1'b1;
                  lcnt  <= LCNT_W'(LATCH_CYC - 1);
                  state <= StLatch;
               end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= StIdle;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            StLatch: begin
               if (lcnt == '0) begin
                  latch <= 1'b0;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  lcnt <= lcnt - 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sreg_sched.sv
// Randomized bench for sreg_sched: a timestamp-based reference model predicts every output,
// and granted words go through a queue checked whenever req_ack fires.
module tb_sreg_sched;

   localparam int N_REQ     = 4;
   localparam int WORD_W    = 42;
   localparam int LATCH_CYC = 4;
   localparam int TIMEOUT   = 16;
   localparam int IDX_W     = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*WORD_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ack;
   logic                    ser_valid;
   logic                    ser_ready;
   logic [WORD_W-1:0]       ser_data;
   logic                    ser_done;
   logic                    latch;
   logic [IDX_W-1:0]        grant_id;
   logic                    busy;
   logic                    err_timeout;

   always #5 clk = ~clk;

   sreg_sched #(
      .N_REQ     (N_REQ),
      .WORD_W    (WORD_W),
      .LATCH_CYC (LATCH_CYC),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ack     (req_ack),
      .ser_valid   (ser_valid),
      .ser_ready   (ser_ready),
      .ser_data    (ser_data),
      .ser_done    (ser_done),
      .latch       (latch),
      .grant_id    (grant_id),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   int tests_run = 0;
   int failed    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: events are tracked by the edge number on which they happen.
   typedef struct {
      int                id;
      logic [WORD_W-1:0] data;
   } grant_t;

   grant_t            exp_q[$];
   int                cyc = 0;
   int                m_last, m_arb_e, m_hs_e, m_done_e, m_idle_after;
   bit                m_issue, m_wait;
   logic [N_REQ-1:0]  e_ack;
   logic              e_valid, e_latch, e_err, e_busy;
   logic [WORD_W-1:0] e_data;
   logic [IDX_W-1:0]  e_gid;

   function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
      for (int k = 1; k <= N_REQ; k++) begin
         if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_issue      = 1'b0;
         m_wait       = 1'b0;
         m_last       = N_REQ - 1;
         m_done_e     = -100;
         m_idle_after = cyc;
         e_ack        = '0;
         e_valid      = 1'b0;
         e_latch      = 1'b0;
         e_err        = 1'b0;
         e_busy       = 1'b0;
         e_data       = '0;
         e_gid        = '0;
         exp_q.delete();
      end else begin
         int w;
         cyc++;
         e_ack = '0;
         e_err = 1'b0;
         if (m_issue) begin
            if (cyc > m_arb_e && ser_ready) begin
               m_issue = 1'b0;
               m_wait  = 1'b1;
               m_hs_e  = cyc;
               e_valid = 1'b0;
            end
         end else if (m_wait) begin
            if (ser_done) begin
               m_wait       = 1'b0;
               m_done_e     = cyc;
               m_idle_after = cyc + LATCH_CYC;
            end else if (cyc - m_hs_e == TIMEOUT) begin
               m_wait       = 1'b0;
               e_err        = 1'b1;
               m_idle_after = cyc;
            end
         end else if (cyc > m_idle_after && req_valid != '0) begin
            w        = rr_pick(req_valid, m_last);
            m_last   = w;
            m_issue  = 1'b1;
            m_arb_e  = cyc;
            e_ack[w] = 1'b1;
            e_valid  = 1'b1;
            e_data   = req_data[w*WORD_W +: WORD_W];
            e_gid    = IDX_W'(w);
            exp_q.push_back('{id: w, data: e_data});
         end
         e_latch = (cyc >= m_done_e) && (cyc < m_done_e + LATCH_CYC);
         e_busy  = m_issue || m_wait || (cyc < m_idle_after);
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         grant_t g;
         check("req_ack", req_ack, e_ack);
         check("ser_valid", ser_valid, e_valid);
         check("latch", latch, e_latch);
         check("err_timeout", err_timeout, e_err);
         check("busy", busy, e_busy);
         check("grant_id", grant_id, e_gid);
         if (e_valid) check("ser_data", ser_data, e_data);
         if (req_ack != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", req_ack, '0);
            end else begin
               g = exp_q.pop_front();
               check("ack_grant_id", grant_id, g.id);
               check("ack_word", ser_data, g.data);
            end
         end
      end
   end

   // Requester and serializer stimulus
   int unsigned req_pct   = 0;
   int unsigned ready_pct = 100;
   int          hs_seen   = -1;
   int          done_k    = 0;

   always @(negedge clk) begin
      logic [63:0] r;
      req_valid = req_valid & ~e_ack;
      for (int i = 0; i < N_REQ; i++) begin
         if (!req_valid[i] && ($urandom_range(99) < req_pct)) begin
            r = {$urandom(), $urandom()};
            req_data[i*WORD_W +: WORD_W] = r[WORD_W-1:0];
            req_valid[i] = 1'b1;
         end
      end
      ser_ready = ($urandom_range(99) < ready_pct);
      if (m_wait && m_hs_e != hs_seen) begin
         hs_seen = m_hs_e;
         case ($urandom_range(9))
            0:       done_k = 0;
            1:       done_k = TIMEOUT;
            2:       done_k = TIMEOUT - 1;
            default: done_k = int'($urandom_range(12, 1));
         endcase
      end
      ser_done = m_wait && (done_k != 0) && (cyc + 1 - m_hs_e == done_k);
   end

   function automatic bit cond(input int kind);
      case (kind)
         0:       return m_wait;
         1:       return e_latch;
         2:       return m_issue;
         default: return !e_busy && (req_valid == '0);
      endcase
   endfunction

   task automatic wait_cond(input int kind, input string what);
      int n = 0;
      while (!cond(kind) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check({"wait_", what}, 64'(n), 64'(0));
   endtask

   task automatic reset_and_check(input string tag);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_req_ack"}, req_ack, '0);
      check({tag, "_ser_valid"}, ser_valid, '0);
      check({tag, "_ser_data"}, ser_data, '0);
      check({tag, "_latch"}, latch, '0);
      check({tag, "_grant_id"}, grant_id, '0);
      check({tag, "_busy"}, busy, '0);
      check({tag, "_err_timeout"}, err_timeout, '0);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      ser_ready = 1'b0;
      ser_done  = 1'b0;
      repeat (3) @(negedge clk);
      reset_and_check("por");

      // Single request with a fixed word
      repeat (2) @(posedge clk);
      #1;
      req_data[0 +: WORD_W] = 42'h2AA_AAAA_AAAA;
      req_valid[0] = 1'b1;
      wait_cond(3, "single");

      // All requesters held valid: strict rotation
      req_pct   = 100;
      ready_pct = 100;
      repeat (200) @(negedge clk);

      // Mixed random traffic and readiness
      req_pct   = 30;
      ready_pct = 60;
      repeat (1500) @(negedge clk);

      // Backpressure: hold ser_ready low for 10 cycles during ISSUE
      req_pct   = 100;
      ready_pct = 0;
      wait_cond(2, "issue");
      repeat (10) @(negedge clk);
      ready_pct = 100;

      // Reset while waiting for the serializer, then while latching
      wait_cond(0, "wait_done");
      reset_and_check("rst_wait");
      wait_cond(1, "latch");
      reset_and_check("rst_latch");
      repeat (150) @(negedge clk);

      req_pct = 0;
      wait_cond(3, "drain");
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
